// File: rtl/tablero_if.sv
// Board generator bus: request, read address, status and read data.
// master = control FSM / display side, slave = tablero_generador.
interface tablero_if #(
   parameter int FILAS    = 8,
   parameter int COLUMNAS = 8
);
   localparam int N  = FILAS * COLUMNAS;
   localparam int FW = $clog2(FILAS);
   localparam int CW = $clog2(COLUMNAS);
   localparam int BW = $clog2(N + 1);

   logic          enable_matriz;
   logic [FW-1:0] leer_fila;
   logic [CW-1:0] leer_col;
   logic          tablero_generado;
   logic          ocupado;
   logic          bomba_leida;
   logic [3:0]    vecinos_leidos;
   logic [BW-1:0] bombas_colocadas;

   modport master (
      output enable_matriz, leer_fila, leer_col,
      input  tablero_generado, ocupado,
      input  bomba_leida, vecinos_leidos,
      input  bombas_colocadas
   );

   modport slave (
      input  enable_matriz, leer_fila, leer_col,
      output tablero_generado, ocupado,
      output bomba_leida, vecinos_leidos,
      output bombas_colocadas
   );
endinterface

// File: rtl/tablero_generador.sv
// Minesweeper board generator: LFSR bomb placement, neighbour counts,
// registered cell read port. Ports: clk, rst (sync, high), bus (slave).
module tablero_generador #(
   parameter int          FILAS      = 8,
   parameter int          COLUMNAS   = 8,
   parameter int          NUM_BOMBAS = 10,
   parameter logic [15:0] SEMILLA    = 16'hACE1
) (
   input logic      clk,
   input logic      rst,
   tablero_if.slave bus
);
   localparam int N  = FILAS * COLUMNAS;
   localparam int AW = $clog2(N);
   localparam int CW = $clog2(COLUMNAS);
   localparam int BW = $clog2(N + 1);
   localparam logic [15:0] SEED =
      (SEMILLA == 16'h0) ? 16'h0001 : SEMILLA;

   typedef enum logic [2:0] {
      IDLE, LIMPIAR, COLOCAR, CONTAR, LISTO
   } estado_t;

   estado_t       estado, sig;
   logic [15:0]   lfsr;
   logic          fb;
   logic          en_q;
   logic          inicio;
   logic [N-1:0]  bomba;
   logic [3:0]    cuenta [N];
   logic [AW-1:0] celda;
   logic [BW-1:0] colocadas;
   logic [BW-1:0] cnt_sig;
   logic [AW-1:0] cand;
   logic          libre;
   logic [AW-1:0] dir;
   logic [3:0]    suma;
   int            r, c;

   assign fb      = lfsr[15] ^ lfsr[13]
                  ^ lfsr[12] ^ lfsr[10];
   assign inicio  = bus.enable_matriz & ~en_q;
   assign cand    = lfsr[AW-1:0];
   assign libre   = ~bomba[cand];
   assign cnt_sig = colocadas + BW'(1);
   assign dir     = {bus.leer_fila, bus.leer_col};

   assign bus.tablero_generado = (estado == LISTO);
   assign bus.ocupado          = (estado == LIMPIAR) ||
                                 (estado == COLOCAR) ||
                                 (estado == CONTAR);
   assign bus.bombas_colocadas = colocadas;

   // Neighbour sum of the cell under celda; off-board cells skipped.
   always_comb begin
      suma = '0;
      r    = 0;
      c    = 0;
      for (int dr = -1; dr <= 1; dr++) begin
         for (int dc = -1; dc <= 1; dc++) begin
            r = int'(celda[AW-1:CW]) + dr;
            c = int'(celda[CW-1:0]) + dc;
            if (!(dr == 0 && dc == 0) &&
                r >= 0 && r < FILAS &&
                c >= 0 && c < COLUMNAS)
               suma = suma +
                  4'(bomba[AW'(r * COLUMNAS + c)]);
         end
      end
   end

   always_comb begin
      sig = estado;
      unique case (estado)
         IDLE:    if (inicio) sig = LIMPIAR;
         LIMPIAR: sig = COLOCAR;
         COLOCAR:
            if (libre && cnt_sig == BW'(NUM_BOMBAS))
               sig = CONTAR;
         CONTAR:
            if (celda == AW'(N - 1)) sig = LISTO;
         LISTO:   if (inicio) sig = LIMPIAR;
         default: sig = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         estado             <= IDLE;
         lfsr               <= SEED;
         en_q               <= 1'b0;
         bomba              <= '0;
         colocadas          <= '0;
         celda              <= '0;
         bus.bomba_leida    <= 1'b0;
         bus.vecinos_leidos <= '0;
         for (int i = 0; i < N; i++)
            cuenta[i] <= '0;
      end else begin
         estado <= sig;
         lfsr   <= {lfsr[14:0], fb};
         en_q   <= bus.enable_matriz;
         case (estado)
            LIMPIAR: begin
               bomba     <= '0;
               colocadas <= '0;
               celda     <= '0;
               for (int i = 0; i < N; i++)
                  cuenta[i] <= '0;
            end
            COLOCAR: begin
               if (libre) begin
                  bomba[cand] <= 1'b1;
                  colocadas   <= cnt_sig;
               end
            end
            CONTAR: begin
               cuenta[celda] <= suma;
               celda         <= celda + AW'(1);
            end
            default: ;
         endcase
         // Keyed on next state so reads are zero in any non-LISTO cycle.
         if (sig == LISTO) begin
            bus.bomba_leida    <= bomba[dir];
            bus.vecinos_leidos <= cuenta[dir];
         end else begin
            bus.bomba_leida    <= 1'b0;
            bus.vecinos_leidos <= '0;
         end
      end
   end
endmodule

// File: tb/tb_tablero_generador.sv
// Directed bench for tablero_generador (8x8, 10 bombs) plus a
// second instance with SEMILLA = 0.
module tb_tablero_generador;
   logic       clk;
   logic       rst;
   logic       en;
   logic [2:0] fila;
   logic [2:0] col;

   int pasadas;
   int total;

   logic [63:0] mapa;
   logic [63:0] mapa1;
   logic [63:0] mapa2;
   logic [3:0]  vec [64];
   logic        vec_nz;
   int          n;

   tablero_if #(.FILAS(8), .COLUMNAS(8)) bus ();
   tablero_if #(.FILAS(8), .COLUMNAS(8)) bz ();

   assign bus.enable_matriz = en;
   assign bus.leer_fila     = fila;
   assign bus.leer_col      = col;
   assign bz.enable_matriz  = en;
   assign bz.leer_fila      = fila;
   assign bz.leer_col       = col;

   tablero_generador dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   tablero_generador #(.SEMILLA(16'h0000)) dut_z (
      .clk (clk),
      .rst (rst),
      .bus (bz)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [63:0] obs,
                      input logic [63:0] exp);
      total++;
      assert (obs === exp) pasadas++;
      else $error("FAIL %s observed=%0h expected=%0h",
                  tag, obs, exp);
   endtask

   function automatic logic [3:0] modelo(
      input logic [63:0] m, input int i);
      int s;
      int rr;
      int cc;
      s = 0;
      for (int dr = -1; dr <= 1; dr++)
         for (int dc = -1; dc <= 1; dc++) begin
            rr = i / 8 + dr;
            cc = i % 8 + dc;
            if (!(dr == 0 && dc == 0) &&
                rr >= 0 && rr < 8 && cc >= 0 && cc < 8)
               s += int'(m[rr * 8 + cc]);
         end
      return 4'(s);
   endfunction

   task automatic barrer();
      vec_nz = 1'b0;
      for (int i = 0; i < 64; i++) begin
         fila = 3'(i / 8);
         col  = 3'(i % 8);
         @(negedge clk);
         mapa[i] = bus.bomba_leida;
         vec[i]  = bus.vecinos_leidos;
         if (bus.vecinos_leidos != 4'd0) vec_nz = 1'b1;
      end
   endtask

   task automatic arrancar();
      en  = 1'b0;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (5) @(negedge clk);
      en = 1'b1;
   endtask

   task automatic esperar_diez(input string tag);
      n = 0;
      while (bus.bombas_colocadas != 7'd10 && n < 3000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 3000) chk(tag, 64'(bus.bombas_colocadas), 64'd10);
   endtask

   task automatic esperar_listo(input string tag);
      n = 0;
      while (!bus.tablero_generado && n < 3000) begin
         @(negedge clk);
         n++;
      end
      chk(tag, 64'(bus.tablero_generado), 64'd1);
   endtask

   task automatic verificar_tablero(input string tag);
      barrer();
      chk({tag, "_bombas"}, 64'($countones(mapa)), 64'd10);
      chk({tag, "_cnt"}, 64'(bus.bombas_colocadas), 64'd10);
      for (int i = 0; i < 64; i++)
         chk($sformatf("%s_vec%0d", tag, i),
             64'(vec[i]), 64'(modelo(mapa, i)));
   endtask

   initial begin
      pasadas = 0;
      total   = 0;
      en      = 1'b0;
      fila    = '0;
      col     = '0;
      rst     = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_gen", 64'(bus.tablero_generado), 64'd0);
      chk("rst_ocup", 64'(bus.ocupado), 64'd0);
      chk("rst_bl", 64'(bus.bomba_leida), 64'd0);
      chk("rst_vl", 64'(bus.vecinos_leidos), 64'd0);
      chk("rst_cnt", 64'(bus.bombas_colocadas), 64'd0);
      chk("rst_lfsr", 64'(dut.lfsr), 64'hACE1);
      chk("rst_lfsr_z", 64'(dut_z.lfsr), 64'h0001);
      rst = 1'b0;
      barrer();
      chk("rst_map", mapa, 64'd0);
      chk("rst_vec", 64'(vec_nz), 64'd0);

      // First board, enable held high throughout.
      arrancar();
      @(negedge clk);
      chk("ocup_rise", 64'(bus.ocupado), 64'd1);
      chk("gen_low", 64'(bus.tablero_generado), 64'd0);
      esperar_diez("wait10_a");
      chk("ocup_colocar", 64'(bus.ocupado), 64'd1);
      n = 0;
      while (!bus.tablero_generado && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("contar_len", 64'(n), 64'd64);
      chk("listo_ocup", 64'(bus.ocupado), 64'd0);
      verificar_tablero("a");
      mapa1 = mapa;

      n = 0;
      while (!bz.tablero_generado && n < 3000) begin
         @(negedge clk);
         n++;
      end
      chk("z_gen", 64'(bz.tablero_generado), 64'd1);
      chk("z_cnt", 64'(bz.bombas_colocadas), 64'd10);

      repeat (20) @(negedge clk);
      chk("hold_gen", 64'(bus.tablero_generado), 64'd1);
      chk("hold_ocup", 64'(bus.ocupado), 64'd0);

      // Re-trigger from LISTO with a fresh rising edge.
      en = 1'b0;
      @(negedge clk);
      en = 1'b1;
      @(negedge clk);
      chk("retrig_gen", 64'(bus.tablero_generado), 64'd0);
      chk("retrig_ocup", 64'(bus.ocupado), 64'd1);
      esperar_listo("wait_b");
      verificar_tablero("b");
      chk("b_differs", 64'(mapa != mapa1), 64'd1);

      // Same start cycle after reset reproduces the first board.
      arrancar();
      esperar_listo("wait_c");
      barrer();
      chk("repro", mapa, mapa1);

      // Reset in the middle of placement.
      arrancar();
      n = 0;
      while (bus.bombas_colocadas != 7'd4 && n < 3000) begin
         @(negedge clk);
         n++;
      end
      chk("mid_cnt4", 64'(bus.bombas_colocadas), 64'd4);
      rst = 1'b1;
      @(negedge clk);
      chk("mid_ocup", 64'(bus.ocupado), 64'd0);
      chk("mid_cnt", 64'(bus.bombas_colocadas), 64'd0);
      chk("mid_gen", 64'(bus.tablero_generado), 64'd0);
      chk("mid_map", 64'(dut.bomba), 64'd0);
      rst = 1'b0;
      en  = 1'b0;
      repeat (3) @(negedge clk);
      chk("mid_idle", 64'(bus.ocupado), 64'd0);

      mapa2 = mapa;
      $display("%0d/%0d checks passed", pasadas, total);
      $finish;
   end
endmodule

// File: doc/tablero_generador.md
Name: tablero_generador

Overview:
Upstream board-generation stage for the minesweeper control FSM. When the FSM asserts enable_matriz, this block places NUM_BOMBAS bombs pseudo-randomly on a FILAS x COLUMNAS board. It then computes the adjacent-bomb count of every cell and raises tablero_generado, which feeds the FSM's tableroGenerado input. It also provides a registered read port that the cell-reveal and display logic use to fetch the bomb bit and neighbour count of each cell.

Parameters:
FILAS, 8, board rows; power of two, 2..16
COLUMNAS, 8, board columns; power of two, 2..16
NUM_BOMBAS, 10, bombs placed; 1 <= NUM_BOMBAS < FILAS*COLUMNAS
SEMILLA, 16'hACE1, LFSR reset seed; value 0 is replaced by 16'h0001

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous reset, active-high
enable_matriz  input  1  generation request from control FSM; level, rising edge acted on
leer_fila  input  $clog2(FILAS)  read row address
leer_col  input  $clog2(COLUMNAS)  read column address
tablero_generado  output  1  board complete and valid; to FSM tableroGenerado
ocupado  output  1  generation in progress
bomba_leida  output  1  bomb bit of addressed cell; registered
vecinos_leidos  output  4  adjacent bomb count (0..8) of addressed cell; registered
bombas_colocadas  output  $clog2(FILAS*COLUMNAS+1)  running bomb count (debug)

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- On rst, all of the following hold on the next edge:
  - state = IDLE; bomb bitmap and count memory cleared; LFSR = SEMILLA (or 1 if SEMILLA = 0).
  - All outputs 0; enable_matriz edge register cleared.
  - rst overrides every other input in every state, including mid-generation.
- LFSR: 16-bit Fibonacci, polynomial x^16+x^14+x^13+x^11+1. Shifts every cycle in every state except reset, so the board depends on when the request arrives.
- Start: inicio = enable_matriz & ~enable_matriz_q. It is honoured only in IDLE or LISTO and ignored in COLOCAR and CONTAR. Holding enable_matriz high never retriggers.
- States:
  - IDLE: wait for inicio, then go to LIMPIAR.
  - LIMPIAR: one cycle. Clears the bitmap and counts, sets bombas_colocadas = 0, tablero_generado = 0, ocupado = 1. Next state is COLOCAR.
  - COLOCAR: one candidate per cycle, idx = lfsr[$clog2(FILAS*COLUMNAS)-1:0], row-major (idx = fila*COLUMNAS + col).
    - If the cell is empty, set its bomb bit and increment bombas_colocadas.
    - If the cell is occupied, discard the candidate (no retry penalty beyond the cycle).
    - When bombas_colocadas reaches NUM_BOMBAS on an edge, go to CONTAR at that edge. Duration is variable and at least NUM_BOMBAS cycles.
  - CONTAR: one cell per cycle, idx 0 to FILAS*COLUMNAS-1.
    - Sum the bomb bits of the up-to-8 neighbours and write the 4-bit sum.
    - Off-board neighbours count 0: row 0 has no north neighbours, the last row no south, column 0 no west, the last column no east. There is no wrap-around.
    - A bomb cell still stores its neighbour count.
    - Takes exactly FILAS*COLUMNAS cycles. After the last cell, go to LISTO.
  - LISTO: tablero_generado = 1 and ocupado = 0, both held until rst or inicio (inicio goes to LIMPIAR, which drops tablero_generado on the following edge).
- tablero_generado rises on the edge after the final CONTAR write, never earlier.
- Read port: bomba_leida and vecinos_leidos are registered with 1-cycle latency from leer_fila/leer_col. Both read 0 whenever state != LISTO.
- Widths: the neighbour sum is computed in 4 bits (max 8, no overflow). The comparison with bombas_colocadas is at full width.

Test Plan:
1. Apply rst for 2 cycles with enable_matriz = 0 -> tablero_generado = ocupado = bomba_leida = 0, vecinos_leidos = 0, bombas_colocadas = 0. Reads return 0 for all 64 cells.
2. Pulse enable_matriz 0->1 with defaults -> ocupado rises the next edge. tablero_generado rises exactly 64 cycles after COLOCAR exits. Sweeping all 64 cells finds exactly 10 bomb bits and bombas_colocadas = 10.
3. In LISTO, compare every vecinos_leidos against a bench model computed from the read bitmap -> all match. Corner cells are <= 3, edge cells <= 5, interior cells <= 8.
4. Assert rst mid-COLOCAR when bombas_colocadas = 4 -> on the next edge the state is IDLE, the count is 0, ocupado = 0, and no bomb bits remain.
5. Hold enable_matriz high through generation and LISTO -> exactly one generation. Then drop it and raise it again -> tablero_generado falls within 2 cycles and the new board again has 10 bombs. The layout differs from the first for the same seed because the LFSR phase differs.
6. Run twice from rst with an identical stimulus start cycle -> identical bitmaps. Set SEMILLA = 0 -> generation still completes (LFSR loaded with 1).
